// File: rtl/inst_fetch_if.sv
// Fetch-side bundle: ROM request/response, ID redirect and the ID handshake.
// The fetch unit takes the master modport; the ROM/ID side takes the slave modport.
interface inst_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              rom_ce;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_inst;
    logic              branch_flag;
    logic [ADDR_W-1:0] branch_target_address;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_pc;
    logic [DATA_W-1:0] out_inst;

    modport master (
        output rom_ce, rom_addr, out_valid, out_pc, out_inst,
        input  rom_inst, branch_flag, branch_target_address, out_ready
    );

    modport slave (
        input  rom_ce, rom_addr, out_valid, out_pc, out_inst,
        output rom_inst, branch_flag, branch_target_address, out_ready
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: PC register, zero-latency ROM access, small tagged FIFO to ID.
// A branch from ID flushes the FIFO and reloads the PC.
module inst_fetch #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int                DEPTH    = 2
) (
    input logic          clk,
    input logic          rst,
    inst_fetch_if.master bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {HOLD, RUN} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } entry_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              push, pop, empty;
    entry_t            mem [DEPTH];
    entry_t            head;

    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        pop       = 1'b0;
        case (state)
            HOLD:    state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = HOLD;
        endcase
        // Branch wins over both ends of the FIFO in its cycle.
        push = (state == RUN) && (count < CNT_W'(DEPTH)) && !bus.branch_flag;
        pop  = !empty && !bus.branch_flag && bus.out_ready;
    end

    assign bus.rom_ce    = push;
    assign bus.rom_addr  = pc;
    assign bus.out_valid = !empty && !bus.branch_flag;
    // Storage is not reset, so gate the head to keep X off the outputs.
    assign bus.out_pc    = empty ? '0 : head.pc;
    assign bus.out_inst  = empty ? '0 : head.inst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= HOLD;
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_nxt;
            if (bus.branch_flag) begin
                pc     <= bus.branch_target_address & ~ADDR_W'(3);
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    pc     <= pc + ADDR_W'(4);
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
                if (push && !pop)      count <= count + CNT_W'(1);
                else if (pop && !push) count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{pc: pc, inst: bus.rom_inst};
    end
endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: queue-based reference model checked every
// cycle, directed literal checks, randomized ready/branch traffic, PC wrap instance.
module tb_inst_fetch;
    localparam int DEPTH = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    inst_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus  ();
    inst_fetch_if #(.ADDR_W(32), .DATA_W(32)) wbus ();

    inst_fetch #(.ADDR_W(32), .DATA_W(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    inst_fetch #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_wrap (
        .clk(clk), .rst(rst), .bus(wbus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    assign bus.rom_inst  = rom_word(bus.rom_addr);
    assign wbus.rom_inst = rom_word(wbus.rom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of fetched {pc, inst} pairs plus the next PC.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc    = RESET_PC;
    bit          running = 0;

    always @(negedge clk) begin
        logic        e_ce, e_valid;
        logic [31:0] e_pc, e_inst;
        if (!rst) begin
            q.delete();
            m_pc    = RESET_PC;
            running = 0;
        end
        e_ce    = rst && running && (q.size() < DEPTH) && !bus.branch_flag;
        e_valid = (q.size() != 0) && !bus.branch_flag;
        e_pc    = (q.size() != 0) ? q[0].pc   : 32'h0;
        e_inst  = (q.size() != 0) ? q[0].inst : 32'h0;
        chk("m_rom_addr",  bus.rom_addr,          m_pc);
        chk("m_rom_ce",    {31'b0, bus.rom_ce},   {31'b0, e_ce});
        chk("m_out_valid", {31'b0, bus.out_valid}, {31'b0, e_valid});
        chk("m_out_pc",    bus.out_pc,   e_pc);
        chk("m_out_inst",  bus.out_inst, e_inst);
        if (rst) begin
            if (bus.branch_flag) begin
                q.delete();
                m_pc = {bus.branch_target_address[31:2], 2'b00};
            end else begin
                if (e_valid && bus.out_ready) void'(q.pop_front());
                if (e_ce) begin
                    q.push_back('{pc: m_pc, inst: rom_word(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
            end
            running = 1;
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.out_ready = 1'b1;
        bus.branch_flag = 1'b0;
        bus.branch_target_address = 32'h0;
        wbus.out_ready = 1'b1;
        wbus.branch_flag = 1'b0;
        wbus.branch_target_address = 32'h0;

        // Reset state and startup sequence
        repeat (3) drive_edge();
        chk("rst_rom_ce", {31'b0, bus.rom_ce}, 32'h0);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("hold_rom_ce", {31'b0, bus.rom_ce}, 32'h0);
        drive_edge(); @(negedge clk);
        chk("run_rom_ce", {31'b0, bus.rom_ce}, 32'h1);
        chk("run_rom_addr", bus.rom_addr, 32'h0);
        chk("wrap_first_addr", wbus.rom_addr, 32'hFFFF_FFF8);
        drive_edge(); @(negedge clk);
        chk("first_valid", {31'b0, bus.out_valid}, 32'h1);
        chk("first_pc", bus.out_pc, 32'h0);
        chk("first_inst", bus.out_inst, 32'h1000_0000);
        chk("wrap_pc0", wbus.out_pc, 32'hFFFF_FFF8);
        drive_edge(); @(negedge clk);
        chk("seq_pc4", bus.out_pc, 32'h4);
        chk("wrap_pc1", wbus.out_pc, 32'hFFFF_FFFC);
        chk("wrap_addr0", wbus.rom_addr, 32'h0);
        drive_edge(); @(negedge clk);
        chk("seq_pc8", bus.out_pc, 32'h8);
        chk("wrap_pc2", wbus.out_pc, 32'h0);
        chk("wrap_inst2", wbus.out_inst, 32'h1000_0000);
        drive_edge(); @(negedge clk);
        chk("seq_pcC", bus.out_pc, 32'hC);

        // Stall for 5 cycles: head 0x10 frozen, FIFO fills, PC stops at 0x18
        drive_edge(); bus.out_ready = 1'b0;
        repeat (4) begin drive_edge(); end
        @(negedge clk);
        chk("stall_pc", bus.out_pc, 32'h10);
        chk("stall_inst", bus.out_inst, 32'h1000_0004);
        chk("stall_rom_ce", {31'b0, bus.rom_ce}, 32'h0);
        chk("stall_rom_addr", bus.rom_addr, 32'h18);
        drive_edge(); bus.out_ready = 1'b1;
        @(negedge clk); chk("drain0", bus.out_pc, 32'h10);
        drive_edge(); @(negedge clk); chk("drain1", bus.out_pc, 32'h14);
        drive_edge(); @(negedge clk); chk("drain2", bus.out_pc, 32'h18);

        // Refill to 2, then branch with out_ready high in the same cycle
        drive_edge(); bus.out_ready = 1'b0;
        drive_edge();
        drive_edge();
        bus.out_ready = 1'b1;
        bus.branch_flag = 1'b1;
        bus.branch_target_address = 32'h0000_0043;
        @(negedge clk);
        chk("br_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("br_rom_ce", {31'b0, bus.rom_ce}, 32'h0);
        drive_edge(); bus.branch_flag = 1'b0;
        @(negedge clk);
        chk("br_tgt_addr", bus.rom_addr, 32'h40);
        chk("br_tgt_ce", {31'b0, bus.rom_ce}, 32'h1);
        chk("br_gap_valid", {31'b0, bus.out_valid}, 32'h0);
        drive_edge(); @(negedge clk);
        chk("br_tgt_pc", bus.out_pc, 32'h40);
        chk("br_tgt_inst", bus.out_inst, 32'h1000_0010);

        // Randomized ready/branch traffic, model-checked every cycle
        for (int i = 0; i < 400; i++) begin
            drive_edge();
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.branch_flag = ($urandom_range(0, 9) == 0);
            bus.branch_target_address = $urandom;
        end

        // Asynchronous reset while valid
        drive_edge();
        bus.out_ready = 1'b1;
        bus.branch_flag = 1'b0;
        repeat (3) drive_edge();
        @(negedge clk);
        chk("pre_rst_valid", {31'b0, bus.out_valid}, 32'h1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("async_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("async_rom_ce", {31'b0, bus.rom_ce}, 32'h0);
        chk("async_pc", bus.rom_addr, RESET_PC);
        drive_edge(); rst = 1'b1;
        @(negedge clk);
        chk("rehold_ce", {31'b0, bus.rom_ce}, 32'h0);
        drive_edge(); @(negedge clk);
        chk("rerun_ce", {31'b0, bus.rom_ce}, 32'h1);
        chk("rerun_addr", bus.rom_addr, RESET_PC);
        drive_edge(); @(negedge clk);
        chk("rerun_pc", bus.out_pc, RESET_PC);

        drive_edge();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
